captura_entrada_io: RTL
=======================

# captura_entrada_io

Input-capture stage feeding the CPU's IN path. Turns the raw board push-button and the 4-bit data switches into a decimal value of up to `DIGITOS_MAX` digits, entered one digit per press. Holds the CPU with a stall request while a read is pending. Delivers the assembled 32-bit binary value with a one-cycle ready pulse. Also echoes the digits entered so far to the seven-segment BCD drivers.

## Interface
Parameters:
- `DIGITOS_MAX`, 3, maximum digits per value (1..9).
- `DEBOUNCE_CICLOS`, 4, number of consecutive stable synchronized samples before a button level is accepted (≥1).

Ports:
- `clock`  in  1  single system clock; everything is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `botaoPlaca`  in  1  raw push-button, asynchronous, active-high.
- `entradaDeDados`  in  4  switch code, sampled on a press: 0–9 digit, E clear, F confirm, A–D invalid.
- `pedidoLeitura`  in  1  level from control unit, high while an IN instruction is executing.
- `aguardando`  out  1  stall request to CPU; high while a read is pending.
- `dadoPronto`  out  1  one-cycle pulse: `dadosLidos` is valid.
- `dadosLidos`  out  32  assembled binary value; held until the next delivery.
- `erroDigito`  out  1  one-cycle pulse on a rejected press.
- `unidade`, `dezena`, `centena`  out  4 each  BCD echo for the displays.

## Operation
- Button path: 2-flop synchronizer, then debounce counter. The accepted level changes only after `DEBOUNCE_CICLOS` equal samples. The rising edge of the accepted level produces exactly one press event (`evento`), one cycle wide.
- The switch code is sampled in the same cycle as `evento`.
- FSM states:
  - OCIOSO:
    - Presses are ignored.
    - If `pedidoLeitura`=1 and `armado`=1: clear accumulator, BCD and digit count, then go to ESPERA.
    - `armado` is set whenever `pedidoLeitura`=0.
  - ESPERA (`aguardando`=1):
    - Digit press with count<`DIGITOS_MAX`: acc ← acc·10 + d, computed as (acc<<3)+(acc<<1)+d in 32 bits. BCD shifts left one digit (centena←dezena, dezena←unidade, unidade←d). count+1.
    - Digit press with count=`DIGITOS_MAX`: ignored, `erroDigito` pulse.
    - Code E: acc, BCD and count cleared; no error.
    - Codes A–D: ignored, `erroDigito` pulse.
    - Code F: `dadosLidos` ← acc, go to ENTREGA. Confirming with zero digits delivers 0.
    - `pedidoLeitura` falling: abort to OCIOSO. No `dadoPronto`; `dadosLidos` unchanged.
  - ENTREGA:
    - `dadoPronto`=1 and `aguardando`=0 for this one cycle.
    - `armado` cleared; next state is OCIOSO.
    - Re-arm requires `pedidoLeitura` to be seen low, so a single long IN never captures twice.
- Press and `pedidoLeitura` fall in the same cycle: abort wins and the press is discarded.
- Reset mid-entry: all state is lost; no `dadoPronto` is produced.

## Timing
- Reset values:
  - State OCIOSO, `armado`=1.
  - `aguardando`=0, `dadoPronto`=0, `erroDigito`=0.
  - `dadosLidos`=0, BCD outputs=0.
  - Synchronizer, debounce counter and accepted level all 0.
- Latency from the pad rising edge to `evento` is 2 + `DEBOUNCE_CICLOS` cycles, provided the input is stable.
- ESPERA is entered one cycle after `pedidoLeitura` rises with `armado`=1; `aguardando` rises in that same cycle.
- Accumulator, BCD and `erroDigito` update on the edge that registers `evento`.
- `dadoPronto` asserts the cycle after the confirm `evento`. `dadosLidos` is stable from that cycle on. `aguardando` falls in the same cycle that `dadoPronto` asserts.
- A bounce shorter than `DEBOUNCE_CICLOS` produces no event.

## Configuration
- `CAPTURA_ECO_EN` defined: `unidade`/`dezena`/`centena` show the in-progress BCD digits and keep the last value after delivery until the next ESPERA clears them.
- `CAPTURA_ECO_EN` not defined:
  - The BCD register is not built and the three outputs are tied to 4'd0.
  - `dadosLidos`, handshake and error behaviour are identical.

## Test plan
- Press sequence with `pedidoLeitura`=1, `DIGITOS_MAX`=3: digits 1, 2, 7, then F -> `dadosLidos`=127, one `dadoPronto` pulse, echo 1/2/7 (with `CAPTURA_ECO_EN`).
- Digits 9, 9, 9, 5, then F -> `erroDigito` pulses on the 5 only, `dadosLidos`=999.
- Code B, then digit 4, code E, digit 6, F -> one `erroDigito`, `dadosLidos`=6.
- F pressed immediately -> `dadosLidos`=0 and `dadoPronto` pulses.
- `pedidoLeitura` held high for 50 cycles after delivery, with more presses -> no second ESPERA and no second `dadoPronto`. Drop to 0, raise to 1 -> `aguardando`=1 again.
- Bounce and abort:
  - Pad glitch of `DEBOUNCE_CICLOS`−1 cycles -> no event.
  - `pedidoLeitura` dropped after digit 3 -> OCIOSO, no `dadoPronto`, `dadosLidos` unchanged.
  - Async reset mid-entry -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/captura_entrada_io.sv
// Input-capture stage for the CPU IN path: debounced push-button digit entry,
// stall request while a read is pending, ready pulse on delivery.
// Optional BCD display echo is built when CAPTURA_ECO_EN is defined.
module captura_entrada_io #(
  parameter int DIGITOS_MAX     = 3,
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        botaoPlaca,
  input  logic [3:0]  entradaDeDados,
  input  logic        pedidoLeitura,
  output logic        aguardando,
  output logic        dadoPronto,
  output logic [31:0] dadosLidos,
  output logic        erroDigito,
  output logic [3:0]  unidade,
  output logic [3:0]  dezena,
  output logic [3:0]  centena
);

  localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] DEB_LIM = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [3:0]    NUM_MAX = 4'(DIGITOS_MAX);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  logic [1:0]    sync_q;
  logic [CW-1:0] cont_q, cont_d;
  logic          nivel_q, nivel_d;
  logic          nivel_ant_q;
  logic          evento;

  estado_t       estado_q, estado_d;
  logic          armado_q, armado_d;
  logic [31:0]   acc_q, acc_d;
  logic [3:0]    num_q, num_d;
  logic [31:0]   dados_q, dados_d;
  logic          erro_q, erro_d;

  logic          inicia_leitura;
  logic          aborta;
  logic          press;
  logic          eh_digito;
  logic          eh_invalido;
  logic          aceita_digito;
  logic          limpa_acc;
  logic          confirma;

  // Button synchronizer, debounce and press-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b00;
      cont_q      <= '0;
      nivel_q     <= 1'b0;
      nivel_ant_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], botaoPlaca};
      cont_q      <= cont_d;
      nivel_q     <= nivel_d;
      nivel_ant_q <= nivel_q;
    end
  end

  // A differing sample advances the count; any agreeing sample restarts it.
  always_comb begin
    cont_d  = '0;
    nivel_d = nivel_q;
    if (sync_q[1] != nivel_q) begin
      if (cont_q == DEB_LIM) begin
        nivel_d = sync_q[1];
      end else begin
        cont_d = cont_q + 1'b1;
      end
    end
  end

  assign evento = nivel_q & ~nivel_ant_q;

  // Press decode; an abort in the same cycle as a press discards the press
  always_comb begin
    inicia_leitura = (estado_q == OCIOSO) && pedidoLeitura && armado_q;
    aborta         = (estado_q == ESPERA) && !pedidoLeitura;
    press          = (estado_q == ESPERA) && pedidoLeitura && evento;
    eh_digito      = (entradaDeDados <= 4'd9);
    eh_invalido    = (entradaDeDados >= 4'hA) && (entradaDeDados <= 4'hD);
    aceita_digito  = press && eh_digito && (num_q < NUM_MAX);
    limpa_acc      = press && (entradaDeDados == 4'hE);
    confirma       = press && (entradaDeDados == 4'hF);
    erro_d         = press && ((eh_digito && (num_q >= NUM_MAX)) || eh_invalido);
  end

  always_comb begin
    estado_d = estado_q;
    armado_d = armado_q;
    unique case (estado_q)
      OCIOSO: begin
        if (!pedidoLeitura) begin
          armado_d = 1'b1;
        end else if (inicia_leitura) begin
          estado_d = ESPERA;
        end
      end
      ESPERA: begin
        if (aborta) begin
          estado_d = OCIOSO;
          armado_d = 1'b1;
        end else if (confirma) begin
          estado_d = ENTREGA;
        end
      end
      ENTREGA: begin
        // Re-arm only after pedidoLeitura is seen low back in OCIOSO.
        armado_d = 1'b0;
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    num_d   = num_q;
    dados_d = dados_q;
    if (inicia_leitura || limpa_acc) begin
      acc_d = 32'd0;
      num_d = 4'd0;
    end else if (aceita_digito) begin
      acc_d = (acc_q << 3) + (acc_q << 1) + {28'd0, entradaDeDados};
      num_d = num_q + 4'd1;
    end
    if (confirma) begin
      dados_d = acc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      armado_q <= 1'b1;
      acc_q    <= 32'd0;
      num_q    <= 4'd0;
      dados_q  <= 32'd0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      armado_q <= armado_d;
      acc_q    <= acc_d;
      num_q    <= num_d;
      dados_q  <= dados_d;
      erro_q   <= erro_d;
    end
  end

  assign aguardando = (estado_q == ESPERA);
  assign dadoPronto = (estado_q == ENTREGA);
  assign dadosLidos = dados_q;
  assign erroDigito = erro_q;

`ifdef CAPTURA_ECO_EN
  // Echo register: shifts in each accepted digit, holds after delivery.
  logic [11:0] bcd_q, bcd_d;

  always_comb begin
    bcd_d = bcd_q;
    if (inicia_leitura || limpa_acc) begin
      bcd_d = 12'd0;
    end else if (aceita_digito) begin
      bcd_d = {bcd_q[7:0], entradaDeDados};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd_q <= 12'd0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign unidade = bcd_q[3:0];
  assign dezena  = bcd_q[7:4];
  assign centena = bcd_q[11:8];
`else
  assign unidade = 4'd0;
  assign dezena  = 4'd0;
  assign centena = 4'd0;
`endif

endmodule
